id_decode_buffer: RTL and testbench
===================================

// Module: id_decode_buffer
// PURPOSE
//  Parametrised successor of the single-register IF/ID decode stage. Sits between IF and EX:
//  - buffers fetched {pc, inst} in a DEPTH-entry queue;
//  - reads rs/rt from the external regfile, with NUM_FWD-source forwarding;
//  - interlocks on load-use hazards;
//  - resolves beq/bne/j/jal/jr, keeping exactly one delay slot and dropping wrong-path fetches.
//  Replaces global stall-vector backpressure with valid/ready handshakes on both sides.
// PARAMETERS
//  DEPTH    4   queue entries (power of 2, >=2)
//  XLEN     32  data/pc width
//  NUM_FWD  3   forwarding sources, index 0 = EX (highest priority), then MEM, WB
// PORTS
//  clk          in   1              clock, all state on posedge
//  resetn       in   1              asynchronous, active-low reset
//  flush        in   1              exception flush: empty queue, clear all flags
//  in_valid     in   1              IF presents {in_pc, in_inst}
//  in_ready     out  1              queue can accept an entry
//  in_pc        in   XLEN           fetch pc
//  in_inst      in   32             fetched instruction
//  rf_raddr1    out  5              regfile read addr = head rs
//  rf_raddr2    out  5              regfile read addr = head rt
//  rf_rdata1    in   XLEN           combinational read data for rf_raddr1
//  rf_rdata2    in   XLEN           combinational read data for rf_raddr2
//  fwd_bus      in   NUM_FWD*38     per source {we, waddr[4:0], wdata[31:0]}, source i at [38*i+:38]
//  fwd_is_load  in   NUM_FWD        source i result comes from a load (not yet available)
//  out_valid    out  1              decoded head offered to EX
//  out_ready    in   1              EX accepts
//  out_pc       out  XLEN           head pc
//  out_inst     out  32             head instruction
//  out_rs_val   out  XLEN           forwarded rs value
//  out_rt_val   out  XLEN           forwarded rt value
//  br_valid     out  1              registered one-cycle redirect pulse to IF
//  br_target    out  XLEN           registered redirect address
// BEHAVIOUR
//  - Reset (async assert, sync release): queue empty, drop_mode=0, ds_pending=0.
//    Outputs at reset: in_ready=1, out_valid=0, br_valid=0, br_target=0.
//  - Queue and ready/valid:
//    - push = in_valid & in_ready & !drop; pop = out_valid & out_ready.
//    - in_ready = (count<DEPTH); no combinational path from out_ready.
//    - Entry pushed in cycle t is earliest at head in t+1. Push and pop in the same cycle are allowed when not full.
//    - Pointers wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
//  - Forwarding, per operand:
//    - Value = wdata of the lowest-index source i with we & waddr==addr & addr!=0, else rf_rdata.
//    - addr==0 always yields 0.
//  - Load-use interlock: out_valid=0 while the head is non-empty and the highest-priority matching source has fwd_is_load=1.
//  - Branch resolution, at pop of a head branch:
//    - beq/bne compare the forwarded values. Target = pc+4+(sext(imm)<<2). j/jal target = {pc+4[31:28], idx, 2'b0}. jr target = rs_val.
//    - Taken (j/jal/jr always): br_valid=1 and br_target are registered for the next cycle.
//    - Taken also flushes every queue entry behind the delay slot. The entry directly behind the branch is kept.
//    - If the delay slot is not yet queued, set ds_pending; the next push is kept as the delay slot.
//    - Then drop_mode=1: in_ready stays high but pushes are discarded until an input with in_pc==br_target arrives.
//      That input is pushed and drop_mode clears.
//    - Not-taken: no pulse, no flush.
//  - Simultaneous events: flush beats everything, including a same-cycle push, pop or branch. Pop-branch plus same-cycle push counts as the delay-slot push when ds_pending.
//  - Reset mid-operation discards all entries and any pending redirect.
// STRUCTURE
//  - Shared package / defines.vh: opcode/funct constants (BEQ, BNE, J, JAL, SPECIAL, JR_FUNCT), FWD_WD=38, IF_TO_ID and ID_TO_EX bus widths.
//  - Sub-module id_inst_fifo (DEPTH, width XLEN+32): push/pop/count/flush_behind_head(keep). Decode, forwarding and branch logic stay in the top.
// TESTING
//  1. Push 4 addiu with out_ready=0 -> in_ready=0 after 4th. Raise out_ready -> 4 pops in order, in_ready=1 next cycle.
//  2. Head rs=8; fwd0={1,8,0x11}, fwd2={1,8,0x33} -> out_rs_val=0x11. rs=0 with fwd0 waddr=0 -> out_rs_val=0.
//  3. Head rs=9, fwd0 matches with fwd_is_load=1 -> out_valid=0. Next cycle MEM matches, no load -> out_valid=1 with the MEM wdata.
//  4. beq at pc 0x100, equal operands, imm=4, queue {beq, ds@0x104, 0x108, 0x10C}:
//     -> br_valid pulse, br_target=0x114; 0x108/0x10C flushed; inputs dropped until in_pc=0x114.
//  5. jal alone in queue (empty delay slot) -> ds_pending; next push @0x104 kept; push @0x108 dropped.
//  6. flush asserted with a push and a taken branch in the same cycle, queue full -> count=0, drop_mode=0, in_ready=1.

Source files
------------

// File: rtl/id_decode_buffer_pkg.sv
// Shared decode constants, forwarding-source layout and bus-width helpers for the ID buffer.
package id_decode_buffer_pkg;

  localparam int INST_W = 32;
  localparam int FWD_WD = 38;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] JR_FUNCT   = 6'h08;

  typedef struct packed {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } fwd_src_t;

  // {pc, inst} from IF, and {pc, inst, rs_val, rt_val} towards EX
  function automatic int if_to_id_w(int xlen);
    return xlen + INST_W;
  endfunction

  function automatic int id_to_ex_w(int xlen);
    return 3 * xlen + INST_W;
  endfunction

endpackage

// File: rtl/id_inst_fifo.sv
// Fetch queue: circular buffer addressed from the head, with an optional trim that keeps
// only the first `keep` entries (head included) before this cycle's pop/push apply.
module id_inst_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             trunc,
  input  logic [CW-1:0]    keep,
  output logic [WIDTH-1:0] head_data,
  output logic [CW-1:0]    count,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_addr;
  logic [CW-1:0]    kept;

  always_comb begin
    kept    = (trunc && (keep < count)) ? keep : count;
    wr_addr = rd_ptr + kept[PW-1:0];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr + PW'(pop);
      count  <= kept + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_addr] <= push_data;
  end

  assign head_data = mem[rd_ptr];
  assign empty     = (count == '0);

endmodule

// File: rtl/id_decode_buffer.sv
// ID stage: queues fetches, forwards operands, interlocks on load-use and resolves
// branches with one delay slot, dropping wrong-path fetches until the target arrives.
module id_decode_buffer
  import id_decode_buffer_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int XLEN    = 32,
  parameter int NUM_FWD = 3
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [XLEN-1:0]           in_pc,
  input  logic [31:0]               in_inst,
  output logic [4:0]                rf_raddr1,
  output logic [4:0]                rf_raddr2,
  input  logic [XLEN-1:0]           rf_rdata1,
  input  logic [XLEN-1:0]           rf_rdata2,
  input  logic [NUM_FWD*FWD_WD-1:0] fwd_bus,
  input  logic [NUM_FWD-1:0]        fwd_is_load,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [XLEN-1:0]           out_pc,
  output logic [31:0]               out_inst,
  output logic [XLEN-1:0]           out_rs_val,
  output logic [XLEN-1:0]           out_rt_val,
  output logic                      br_valid,
  output logic [XLEN-1:0]           br_target
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = if_to_id_w(XLEN);

  logic [EW-1:0]                 head;
  logic [CW-1:0]                 count;
  logic                          empty, push, pop, accept, drop, branch_fire;
  logic                          drop_mode, ds_pending;
  logic [XLEN-1:0]               head_pc, pc4, rs_val, rt_val, tgt;
  logic [31:0]                   head_inst;
  logic [4:0]                    rs, rt;
  logic                          rs_ld, rt_ld, taken;
  fwd_src_t                      src;
  logic [id_to_ex_w(XLEN)-1:0]   ex_bus;

  assign head_pc   = head[EW-1:32];
  assign head_inst = head[31:0];
  assign rs        = head_inst[25:21];
  assign rt        = head_inst[20:16];
  assign rf_raddr1 = rs;
  assign rf_raddr2 = rt;

  // Walk sources lowest priority first so the lowest index wins
  always_comb begin
    rs_val = rf_rdata1;
    rt_val = rf_rdata2;
    rs_ld  = 1'b0;
    rt_ld  = 1'b0;
    src    = '0;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      src = fwd_src_t'(fwd_bus[FWD_WD*i +: FWD_WD]);
      if (src.we && src.waddr == rs && rs != 5'd0) begin
        rs_val = XLEN'(src.wdata);
        rs_ld  = fwd_is_load[i];
      end
      if (src.we && src.waddr == rt && rt != 5'd0) begin
        rt_val = XLEN'(src.wdata);
        rt_ld  = fwd_is_load[i];
      end
    end
    if (rs == 5'd0) rs_val = '0;
    if (rt == 5'd0) rt_val = '0;
  end

  always_comb begin
    pc4   = head_pc + XLEN'(4);
    taken = 1'b0;
    tgt   = '0;
    unique case (head_inst[31:26])
      OP_BEQ: begin
        taken = (rs_val == rt_val);
        tgt   = pc4 + {{(XLEN-18){head_inst[15]}}, head_inst[15:0], 2'b00};
      end
      OP_BNE: begin
        taken = (rs_val != rt_val);
        tgt   = pc4 + {{(XLEN-18){head_inst[15]}}, head_inst[15:0], 2'b00};
      end
      OP_J, OP_JAL: begin
        taken = 1'b1;
        tgt   = {pc4[XLEN-1:28], head_inst[25:0], 2'b00};
      end
      OP_SPECIAL: begin
        taken = (head_inst[5:0] == JR_FUNCT);
        tgt   = rs_val;
      end
      default: ;
    endcase
  end

  assign in_ready    = (count < CW'(DEPTH));
  assign out_valid   = !empty && !rs_ld && !rt_ld;
  assign pop         = out_valid && out_ready;
  assign accept      = in_valid && in_ready;
  assign drop        = drop_mode && !ds_pending && (in_pc != br_target);
  assign branch_fire = pop && taken && !flush;
  // A push alongside a taken branch is only the delay slot when nothing sits behind the branch
  assign push        = accept && !drop && !(branch_fire && count > CW'(1));

  id_inst_fifo #(.DEPTH(DEPTH), .WIDTH(EW)) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .flush     (flush),
    .push      (push),
    .push_data ({in_pc, in_inst}),
    .pop       (pop),
    .trunc     (branch_fire),
    .keep      (CW'(2)),
    .head_data (head),
    .count     (count),
    .empty     (empty)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      br_valid   <= 1'b0;
      br_target  <= '0;
      drop_mode  <= 1'b0;
      ds_pending <= 1'b0;
    end else if (flush) begin
      br_valid   <= 1'b0;
      drop_mode  <= 1'b0;
      ds_pending <= 1'b0;
    end else begin
      br_valid <= branch_fire;
      if (branch_fire) begin
        br_target  <= tgt;
        drop_mode  <= 1'b1;
        ds_pending <= (count == CW'(1)) && !push;
      end else if (ds_pending && accept) begin
        ds_pending <= 1'b0;
      end else if (drop_mode && accept && in_pc == br_target) begin
        drop_mode <= 1'b0;
      end
    end
  end

  assign ex_bus = {head_pc, head_inst, rs_val, rt_val};
  assign {out_pc, out_inst, out_rs_val, out_rt_val} = ex_bus;

endmodule

// File: tb/tb_id_decode_buffer.sv
// Directed bench for id_decode_buffer: forwarding/interlock table plus queue, branch and flush sequences.
module tb_id_decode_buffer;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [31:0]  in_pc = '0;
  logic [31:0]  in_inst = '0;
  logic [4:0]   rf_raddr1, rf_raddr2;
  logic [31:0]  rf_rdata1, rf_rdata2;
  logic [113:0] fwd_bus = '0;
  logic [2:0]   fwd_is_load = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [31:0]  out_pc, out_inst, out_rs_val, out_rt_val;
  logic         br_valid;
  logic [31:0]  br_target;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Register file model: register r reads 0x1000 + r
  assign rf_rdata1 = 32'h1000 + {27'b0, rf_raddr1};
  assign rf_rdata2 = 32'h1000 + {27'b0, rf_raddr2};

  id_decode_buffer dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .fwd_bus(fwd_bus), .fwd_is_load(fwd_is_load),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
    .out_rs_val(out_rs_val), .out_rt_val(out_rt_val),
    .br_valid(br_valid), .br_target(br_target)
  );

  typedef struct {
    logic [4:0]  rs, rt;
    logic [37:0] f0, f1, f2;
    logic [2:0]  ld;
    logic [31:0] exp_rs, exp_rt;
    logic        exp_valid;
  } vec_t;

  vec_t vecs[8];

  function automatic logic [37:0] mkf(input logic we, input logic [4:0] a, input logic [31:0] d);
    return {we, a, d};
  endfunction

  function automatic logic [31:0] addiu(input logic [4:0] rs, input logic [4:0] rt);
    return {6'h09, rs, rt, 16'h0001};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic push1(input logic [31:0] pc, input logic [31:0] inst);
    in_valid = 1'b1;
    in_pc    = pc;
    in_inst  = inst;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{5'd8, 5'd3, mkf(1,8,32'h11), '0, mkf(1,8,32'h33), 3'b000, 32'h11, 32'h1003, 1'b1};
    vecs[1] = '{5'd0, 5'd5, mkf(1,0,32'h55), '0, '0, 3'b000, 32'h0, 32'h1005, 1'b1};
    vecs[2] = '{5'd9, 5'd4, mkf(1,9,32'h99), '0, '0, 3'b001, 32'h99, 32'h1004, 1'b0};
    vecs[3] = '{5'd9, 5'd4, '0, mkf(1,9,32'h77), '0, 3'b000, 32'h77, 32'h1004, 1'b1};
    vecs[4] = '{5'd7, 5'd7, '0, mkf(0,7,32'h44), mkf(1,7,32'h22), 3'b000, 32'h22, 32'h22, 1'b1};
    vecs[5] = '{5'd2, 5'd6, '0, mkf(1,6,32'h66), '0, 3'b100, 32'h1002, 32'h66, 1'b1};
    vecs[6] = '{5'd3, 5'd6, mkf(1,6,32'hAA), mkf(1,6,32'hBB), '0, 3'b001, 32'h1003, 32'hAA, 1'b0};
    vecs[7] = '{5'd10, 5'd0, '0, '0, mkf(1,10,32'hCC), 3'b100, 32'hCC, 32'h0, 1'b0};

    @(negedge clk);
    #1;
    check("reset in_ready", {31'b0, in_ready}, 32'd1);
    check("reset out_valid", {31'b0, out_valid}, 32'd0);
    check("reset br_valid", {31'b0, br_valid}, 32'd0);
    check("reset br_target", br_target, 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    step();

    // Fill to full with EX stalled, then drain in order
    for (int i = 0; i < 4; i++) push1(32'(i * 4), addiu(5'd1, 5'd2));
    check("full in_ready", {31'b0, in_ready}, 32'd0);
    check("full head pc", out_pc, 32'h0);
    out_ready = 1'b1;
    step();
    check("drain pc1", out_pc, 32'h4);
    check("drain in_ready", {31'b0, in_ready}, 32'd1);
    step();
    check("drain pc2", out_pc, 32'h8);
    step();
    check("drain pc3", out_pc, 32'hC);
    step();
    check("drained out_valid", {31'b0, out_valid}, 32'd0);
    out_ready = 1'b0;

    for (int k = 0; k < 8; k++) begin
      fwd_bus = '0;
      fwd_is_load = '0;
      do_flush();
      push1(32'h1000 + 32'(k * 4), addiu(vecs[k].rs, vecs[k].rt));
      fwd_bus = {vecs[k].f2, vecs[k].f1, vecs[k].f0};
      fwd_is_load = vecs[k].ld;
      #1;
      check($sformatf("vec%0d rs_val", k), out_rs_val, vecs[k].exp_rs);
      check($sformatf("vec%0d rt_val", k), out_rt_val, vecs[k].exp_rt);
      check($sformatf("vec%0d out_valid", k), {31'b0, out_valid}, {31'b0, vecs[k].exp_valid});
    end
    fwd_bus = '0;
    fwd_is_load = '0;

    // Taken beq with delay slot queued; younger entries flushed and wrong path dropped
    do_flush();
    push1(32'h100, {6'h04, 5'd1, 5'd1, 16'd4});
    push1(32'h104, addiu(5'd1, 5'd2));
    push1(32'h108, addiu(5'd1, 5'd2));
    push1(32'h10C, addiu(5'd1, 5'd2));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("beq br_valid", {31'b0, br_valid}, 32'd1);
    check("beq br_target", br_target, 32'h114);
    check("beq delay slot head", out_pc, 32'h104);
    push1(32'h108, addiu(5'd1, 5'd2));
    check("beq pulse one cycle", {31'b0, br_valid}, 32'd0);
    push1(32'h110, addiu(5'd1, 5'd2));
    push1(32'h114, addiu(5'd1, 5'd2));
    out_ready = 1'b1;
    step();
    check("beq target after ds", out_pc, 32'h114);
    step();
    check("beq queue empty", {31'b0, out_valid}, 32'd0);
    out_ready = 1'b0;

    // jal with no delay slot queued yet
    do_flush();
    push1(32'h200, {6'h03, 26'h40});
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("jal br_valid", {31'b0, br_valid}, 32'd1);
    check("jal br_target", br_target, 32'h100);
    check("jal empty after pop", {31'b0, out_valid}, 32'd0);
    push1(32'h204, addiu(5'd1, 5'd2));
    push1(32'h208, addiu(5'd1, 5'd2));
    push1(32'h100, addiu(5'd1, 5'd2));
    check("jal ds kept", out_pc, 32'h204);
    out_ready = 1'b1;
    step();
    check("jal wrong path dropped", out_pc, 32'h100);
    step();
    check("jal queue empty", {31'b0, out_valid}, 32'd0);
    out_ready = 1'b0;

    // Not-taken bne keeps everything behind it
    do_flush();
    push1(32'h300, {6'h05, 5'd1, 5'd1, 16'd8});
    push1(32'h304, addiu(5'd1, 5'd2));
    push1(32'h308, addiu(5'd1, 5'd2));
    out_ready = 1'b1;
    step();
    check("bne no pulse", {31'b0, br_valid}, 32'd0);
    check("bne next head", out_pc, 32'h304);
    step();
    check("bne not flushed", out_pc, 32'h308);
    out_ready = 1'b0;

    // jr jumps to the rs register value
    do_flush();
    push1(32'h400, {6'h00, 5'd5, 15'd0, 6'h08});
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("jr br_valid", {31'b0, br_valid}, 32'd1);
    check("jr br_target", br_target, 32'h1005);

    // Flush wins over a same-cycle push attempt, pop and taken branch
    do_flush();
    push1(32'h500, {6'h04, 5'd1, 5'd1, 16'd4});
    push1(32'h504, addiu(5'd1, 5'd2));
    push1(32'h508, addiu(5'd1, 5'd2));
    push1(32'h50C, addiu(5'd1, 5'd2));
    flush = 1'b1;
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_pc = 32'h510;
    in_inst = addiu(5'd1, 5'd2);
    step();
    flush = 1'b0;
    out_ready = 1'b0;
    in_valid = 1'b0;
    check("flush out_valid", {31'b0, out_valid}, 32'd0);
    check("flush in_ready", {31'b0, in_ready}, 32'd1);
    check("flush br_valid", {31'b0, br_valid}, 32'd0);
    push1(32'h600, addiu(5'd1, 5'd2));
    check("flush drop cleared", out_pc, 32'h600);
    check("flush accepts", {31'b0, out_valid}, 32'd1);

    // Asynchronous reset mid-operation
    #2;
    resetn = 1'b0;
    #1;
    check("async reset out_valid", {31'b0, out_valid}, 32'd0);
    check("async reset br_target", br_target, 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    step();
    check("post reset in_ready", {31'b0, in_ready}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
